// File: rtl/match_result_uart_tx.sv
// match_result_uart_tx: UART 8N1 sender of template-match results; MATCH_TX_CHECKSUM_EN appends an XOR checksum byte
module match_result_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid,
  input  logic       no_match,
  input  logic [9:0] x_in,
  input  logic [8:0] y_in,
  output logic       tx,
  output logic       busy,
  output logic       send_complete
);
  localparam int BW = $clog2(CLKS_PER_BIT);
`ifdef MATCH_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd4;
`else
  localparam logic [2:0] LAST_BYTE = 3'd3;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
  state_t state;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx, byte_idx;
  logic status;
  logic [9:0] x;
  logic [8:0] y;
  logic [7:0] b1, cur_byte;
  logic bit_end;
  assign b1 = {status, 4'b0000, y[8], x[9:8]};
  assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
`ifdef MATCH_TX_CHECKSUM_EN
  assign cur_byte = byte_idx == 3'd0 ? HEADER_BYTE :
                    byte_idx == 3'd1 ? b1 :
                    byte_idx == 3'd2 ? x[7:0] :
                    byte_idx == 3'd3 ? y[7:0] : HEADER_BYTE ^ b1 ^ x[7:0] ^ y[7:0];
`else
  assign cur_byte = byte_idx == 3'd0 ? HEADER_BYTE :
                    byte_idx == 3'd1 ? b1 :
                    byte_idx == 3'd2 ? x[7:0] : y[7:0];
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      status <= 1'b0;
      x <= '0;
      y <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
      send_complete <= 1'b0;
    end else begin
      send_complete <= 1'b0;
      baud <= (state == IDLE || state == DONE || bit_end) ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (valid || no_match) begin
          status <= valid;
          x <= x_in;
          y <= y_in;
          byte_idx <= '0;
          busy <= 1'b1;
          tx <= 1'b0;
          state <= START;
        end
        START: if (bit_end) begin
          bit_idx <= '0;
          tx <= cur_byte[0];
          state <= DATA;
        end
        DATA: if (bit_end) begin
          bit_idx <= bit_idx + 3'd1;
          tx <= bit_idx == 3'd7 ? 1'b1 : cur_byte[bit_idx + 3'd1];
          state <= bit_idx == 3'd7 ? STOP : DATA;
        end
        STOP: if (bit_end) begin
          byte_idx <= byte_idx + 3'd1;
          tx <= byte_idx == LAST_BYTE;
          send_complete <= byte_idx == LAST_BYTE;
          state <= byte_idx == LAST_BYTE ? DONE : START;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_match_result_uart_tx.sv
// tb_match_result_uart_tx: randomized packets checked cycle-by-cycle against an ideal UART frame model
module tb_match_result_uart_tx;
  localparam int N = 4;
`ifdef MATCH_TX_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int PKT = NB * 10 * N;
  logic clock = 1'b0, reset = 1'b1, valid = 1'b0, no_match = 1'b0;
  logic [9:0] x_in = '0;
  logic [8:0] y_in = '0;
  logic tx, busy, send_complete;
  int checks = 0, failures = 0;
  always #5 clock = ~clock;
  match_result_uart_tx #(.CLKS_PER_BIT(N), .HEADER_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .valid(valid), .no_match(no_match),
    .x_in(x_in), .y_in(y_in), .tx(tx), .busy(busy), .send_complete(send_complete)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Strobe one packet, then follow it cycle by cycle until the idle cycle after send_complete.
  task automatic packet(input logic v, input logic nm, input logic [9:0] x, input logic [8:0] y, input int poke_at);
    logic [7:0] b [5];
    logic [7:0] rx;
    logic e;
    int bn, pos;
    rx = '0;
    b[0] = 8'hA5;
    b[1] = {v, 4'b0000, y[8], x[9:8]};
    b[2] = x[7:0];
    b[3] = y[7:0];
    b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
    valid = v;
    no_match = nm;
    x_in = x;
    y_in = y;
    @(negedge clock);
    valid = 1'b0;
    no_match = 1'b0;
    x_in = 10'($urandom);
    y_in = 9'($urandom);
    for (int k = 0; k <= PKT + 1; k++) begin
      if (k == poke_at) begin
        valid = 1'b1;
        no_match = 1'($urandom);
        x_in = 10'($urandom);
        y_in = 9'($urandom);
      end else if (k == poke_at + 1) begin
        valid = 1'b0;
        no_match = 1'b0;
      end
      bn = k / N;
      pos = bn % 10;
      if (k < PKT) begin
        e = pos == 0 ? 1'b0 : pos == 9 ? 1'b1 : b[bn / 10][pos - 1];
        chk("tx", tx, e);
        chk("busy", busy, 1);
        chk("send_complete", send_complete, 0);
        if (k % N == N / 2 && pos >= 1 && pos <= 8) rx[pos - 1] = tx;
        if (k % N == N / 2 && pos == 8) chk($sformatf("byte%0d", bn / 10), rx, b[bn / 10]);
      end else if (k == PKT) begin
        chk("done_pulse", send_complete, 1);
        chk("done_busy", busy, 1);
        chk("done_tx", tx, 1);
      end else begin
        chk("after_pulse", send_complete, 0);
        chk("after_busy", busy, 0);
        chk("after_tx", tx, 1);
      end
      if (k <= PKT) @(negedge clock);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_tx", tx, 1);
      chk("idle_busy", busy, 0);
      chk("idle_sc", send_complete, 0);
      @(negedge clock);
    end
  endtask
  initial begin
    logic v, nm;
    repeat (3) @(negedge clock);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sc", send_complete, 0);
    reset = 1'b0;
    idle(100);
    packet(1'b1, 1'b0, 10'h155, 9'h1AB, -1);
    packet(1'b0, 1'b1, 10'h000, 9'h000, -1);
    idle(2);
    packet(1'b1, 1'b1, 10'h3FF, 9'h1FF, 50);
    idle(1);
    valid = 1'b1;
    x_in = 10'h300;
    y_in = 9'h0AB;
    @(negedge clock);
    valid = 1'b0;
    repeat (22 * N + 1) @(negedge clock);
    chk("pre_abort_tx", tx, 0);
    #2 reset = 1'b1;
    #1 chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("abort_sc", send_complete, 0);
    end
    reset = 1'b0;
    idle(3);
    packet(1'b1, 1'b0, 10'h155, 9'h1AB, 10);
    for (int i = 0; i < 6; i++) begin
      v = 1'($urandom);
      nm = v ? 1'($urandom) : 1'b1;
      idle($urandom_range(0, 3));
      packet(v, nm, 10'($urandom), 9'($urandom), $urandom_range(0, 1) ? int'($urandom_range(0, PKT - 2)) : -1);
    end
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
